// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and the writeback request record used by the
// register writeback controller.
package cpu_pkg;

  localparam int IMM_WIDTH      = 8;
  localparam int REG_ADDR_WIDTH = 3;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [IMM_WIDTH-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/regs_scoreboard.sv
// Pending-write scoreboard: tracks reserved destination registers, gates new
// reservations (WAW) and flags read hazards for the issue stage.
module regs_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_ready,
  input  logic [ADDR_WIDTH-1:0] chk_addr1,
  input  logic [ADDR_WIDTH-1:0] chk_addr2,
  output logic                  hazard,
  input  logic                  rf_w,
  input  logic [ADDR_WIDTH-1:0] rf_waddr
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  always_comb begin
    rsv_ready = !reset && ((rsv_addr == '0) || !pending_q[rsv_addr] ||
                           (rf_w && (rf_waddr == rsv_addr)));
    hazard    = ((chk_addr1 != '0) && pending_q[chk_addr1]) ||
                ((chk_addr2 != '0) && pending_q[chk_addr2]);
    set_mask  = '0;
    clr_mask  = '0;
    if (rsv_valid && rsv_ready && (rsv_addr != '0)) set_mask[rsv_addr] = 1'b1;
    if (rf_w) clr_mask[rf_waddr] = 1'b1;
    // A reservation landing on the edge that retires the old write stays set.
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

endmodule

// File: rtl/regs_wb_ctrl.sv
// Register-file writeback controller: round-robin arbitration between the ALU
// and load/multi-cycle requesters, one-cycle registered write port, scoreboard.
module regs_wb_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = IMM_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_ready,
  input  logic [ADDR_WIDTH-1:0] chk_addr1,
  input  logic [ADDR_WIDTH-1:0] chk_addr2,
  output logic                  hazard,
  output logic                  rf_w,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic                  rr_q, rr_d;
  logic                  rf_w_q, rf_w_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  // rr_q=0 favours requester 0 on contention; it flips only when both ask.
  always_comb begin
    req0_ready = !reset && req0_valid && (!req1_valid || !rr_q);
    req1_ready = !reset && req1_valid && (!req0_valid || rr_q);
    rr_d       = (req0_valid && req1_valid) ? !rr_q : rr_q;
    rf_w_d     = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (req0_ready) begin
      rf_w_d     = (req0_addr != '0);
      rf_waddr_d = req0_addr;
      rf_wdata_d = req0_data;
    end else if (req1_ready) begin
      rf_w_d     = (req1_addr != '0);
      rf_waddr_d = req1_addr;
      rf_wdata_d = req1_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q       <= 1'b0;
      rf_w_q     <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rr_q       <= rr_d;
      rf_w_q     <= rf_w_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_w     = rf_w_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  regs_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rsv_valid(rsv_valid),
    .rsv_addr (rsv_addr),
    .rsv_ready(rsv_ready),
    .chk_addr1(chk_addr1),
    .chk_addr2(chk_addr2),
    .hazard   (hazard),
    .rf_w     (rf_w_q),
    .rf_waddr (rf_waddr_q)
  );

endmodule
